ulpi_pkt_framer: RTL and testbench

- Drain-side controller for the ULPI receiver's INFO and DATA FIFOs.
- For each INFO entry (packet descriptor) it reads the matching payload bytes out of the DATA FIFO. It serialises them as one framed record onto a byte-wide valid/ready sink, which normally feeds the UART TX.
- It gates the receiver's ReadAllow so no new packet is accepted while either FIFO is full.
- It keeps sticky overflow status and a sent-packet counter.

---
 rtl/ulpi_pkg.sv | 30 +++
 rtl/ulpi_pkt_framer.sv | 171 +++++++++++++++++
 tb/tb_ulpi_pkt_framer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_pkg
// Purpose  : Shared constants and state encoding for the ULPI packet framer.
// Revision : 1.0 - initial release
// ============================================================================
package ulpi_pkg;

   // Default record sync byte and field layout of the 16-bit INFO word
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         CNT_W_DEF     = 10;
   localparam int         RXCMD_LSB     = 10;
   localparam int         PKT_CNT_W_DEF = 16;
   localparam int         INFO_W        = 16;

   // Framer state encoding
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_INFO_WAIT = 4'd1,
      ST_SYNC      = 4'd2,
      ST_HDR_HI    = 4'd3,
      ST_HDR_LO    = 4'd4,
      ST_DATA_RD   = 4'd5,
      ST_DATA_WAIT = 4'd6,
      ST_DATA_TX   = 4'd7,
      ST_CSUM      = 4'd8
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ulpi_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_pkt_framer
// Purpose  : Drains ULPI INFO/DATA FIFOs and serialises each packet as a
//            framed record (SYNC, INFO hi, INFO lo, payload, XOR checksum)
//            onto a byte-wide valid/ready sink. Gates receiver ReadAllow
//            and keeps sticky overflow status plus a sent-record counter.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_pkt_framer
   import ulpi_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         CNT_W     = CNT_W_DEF,
   parameter int         PKT_CNT_W = PKT_CNT_W_DEF
) (
   input  logic                  clk_ULPI,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr_ovf,
   output logic                  ReadAllow,
   output logic                  INFO_re,
   input  logic [INFO_W-1:0]     INFO_DATA,
   input  logic                  INFO_empty,
   input  logic                  INFO_full,
   output logic                  DATA_re,
   input  logic [7:0]            USB_DATA,
   input  logic                  DATA_empty,
   input  logic                  DATA_full,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  ovf,
   output logic [PKT_CNT_W-1:0]  pkt_cnt
);

   localparam logic [CNT_W-1:0]     REM_ONE = CNT_W'(1);
   localparam logic [PKT_CNT_W-1:0] PKT_ONE = PKT_CNT_W'(1);

   state_t              state;
   logic [INFO_W-1:0]   info_word;
   logic [CNT_W-1:0]    remaining;
   logic [7:0]          csum;
   logic                tx_accept;

   assign tx_accept = tx_valid && tx_ready;

   // Receiver gating and sticky overflow flag; a set outranks a clear
   always_ff @(negedge clk_ULPI or negedge rst) begin
      if (!rst) begin
         ReadAllow <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         ReadAllow <= en && !INFO_full && !DATA_full;
         if ((INFO_full || DATA_full) && ReadAllow)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

   // Record framer: every output is registered. Each byte is loaded while
   // tx_valid is low and dropped on acceptance, so the sink sees at most one
   // byte every two cycles. FIFO read data is registered by the FIFO on the
   // edge that sees the strobe, so the WAIT states sample it one edge later
   // (once the strobe has fallen).
   always_ff @(negedge clk_ULPI or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         INFO_re   <= 1'b0;
         DATA_re   <= 1'b0;
         info_word <= '0;
         remaining <= '0;
         csum      <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         pkt_cnt   <= '0;
      end else begin
         INFO_re <= 1'b0;
         DATA_re <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!INFO_empty) begin
                  INFO_re <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ST_INFO_WAIT;
               end
            end
            ST_INFO_WAIT: begin
               if (!INFO_re) begin
                  info_word <= INFO_DATA;
                  remaining <= INFO_DATA[CNT_W-1:0];
                  csum      <= '0;
                  state     <= ST_SYNC;
               end
            end
            ST_SYNC: begin
               if (!tx_valid) begin
                  tx_data  <= SYNC_BYTE;
                  tx_valid <= 1'b1;
               end else if (tx_accept) begin
                  tx_valid <= 1'b0;
                  state    <= ST_HDR_HI;
               end
            end
            ST_HDR_HI: begin
               if (!tx_valid) begin
                  tx_data  <= info_word[15:8];
                  tx_valid <= 1'b1;
                  csum     <= csum ^ info_word[15:8];
               end else if (tx_accept) begin
                  tx_valid <= 1'b0;
                  state    <= ST_HDR_LO;
               end
            end
            ST_HDR_LO: begin
               if (!tx_valid) begin
                  tx_data  <= info_word[7:0];
                  tx_valid <= 1'b1;
                  csum     <= csum ^ info_word[7:0];
               end else if (tx_accept) begin
                  tx_valid <= 1'b0;
                  state    <= (remaining != '0) ? ST_DATA_RD : ST_CSUM;
               end
            end
            ST_DATA_RD: begin
               // No timeout: an empty DATA FIFO simply stalls the record
               if (!DATA_empty) begin
                  DATA_re <= 1'b1;
                  state   <= ST_DATA_WAIT;
               end
            end
            ST_DATA_WAIT: begin
               if (!DATA_re) begin
                  tx_data  <= USB_DATA;
                  tx_valid <= 1'b1;
                  csum     <= csum ^ USB_DATA;
                  state    <= ST_DATA_TX;
               end
            end
            ST_DATA_TX: begin
               if (tx_accept) begin
                  tx_valid  <= 1'b0;
                  remaining <= remaining - REM_ONE;
                  state     <= (remaining == REM_ONE) ? ST_CSUM : ST_DATA_RD;
               end
            end
            ST_CSUM: begin
               if (!tx_valid) begin
                  tx_data  <= csum;
                  tx_valid <= 1'b1;
               end else if (tx_accept) begin
                  tx_valid <= 1'b0;
                  pkt_cnt  <= pkt_cnt + PKT_ONE;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulpi_pkt_framer
// Purpose  : Scoreboard bench for ulpi_pkt_framer with behavioural FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_pkt_framer;

   logic        clk_ULPI = 1'b0;
   logic        rst      = 1'b1;
   logic        en       = 1'b0;
   logic        clr_ovf  = 1'b0;
   logic        ReadAllow;
   logic        INFO_re;
   logic [15:0] INFO_DATA  = '0;
   logic        INFO_empty = 1'b1;
   logic        INFO_full  = 1'b0;
   logic        DATA_re;
   logic [7:0]  USB_DATA   = '0;
   logic        DATA_empty = 1'b1;
   logic        DATA_full  = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready   = 1'b1;
   logic        busy;
   logic        ovf;
   logic [15:0] pkt_cnt;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int info_re_cnt = 0;
   int data_re_cnt = 0;
   bit rdy_rand = 1'b0;

   logic [15:0] info_q [$];
   logic [7:0]  data_q [$];
   logic [7:0]  exp_q  [$];

   ulpi_pkt_framer dut (
      .clk_ULPI   (clk_ULPI),
      .rst        (rst),
      .en         (en),
      .clr_ovf    (clr_ovf),
      .ReadAllow  (ReadAllow),
      .INFO_re    (INFO_re),
      .INFO_DATA  (INFO_DATA),
      .INFO_empty (INFO_empty),
      .INFO_full  (INFO_full),
      .DATA_re    (DATA_re),
      .USB_DATA   (USB_DATA),
      .DATA_empty (DATA_empty),
      .DATA_full  (DATA_full),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .ovf        (ovf),
      .pkt_cnt    (pkt_cnt)
   );

   // 60 MHz-ish clock; the design works on the falling edge
   initial forever #8 clk_ULPI = ~clk_ULPI;

   // Global time limit
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Sink ready: settles just after the active edge so it is stable for the next one
   always @(negedge clk_ULPI) begin
      #1;
      tx_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Behavioural FIFOs: read data registered on the edge that sees re
   always @(negedge clk_ULPI or negedge rst) begin
      if (!rst) begin
         INFO_empty <= 1'b1;
         DATA_empty <= 1'b1;
         INFO_DATA  <= '0;
         USB_DATA   <= '0;
      end else begin
         if (INFO_re) begin
            info_re_cnt++;
            if (info_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL info_underflow: INFO_re=1 while INFO FIFO empty");
            end else begin
               INFO_DATA <= info_q.pop_front();
            end
         end
         if (DATA_re) begin
            data_re_cnt++;
            if (data_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL data_underflow: DATA_re=1 while DATA FIFO empty");
            end else begin
               USB_DATA <= data_q.pop_front();
            end
         end
         INFO_empty <= (info_q.size() == 0);
         DATA_empty <= (data_q.size() == 0);
      end
   end

   // Monitor: pops the scoreboard on every accepted byte, checks hold stability
   logic       prev_v = 1'b0;
   logic       prev_r = 1'b0;
   logic [7:0] prev_d = '0;
   always @(posedge clk_ULPI) begin
      logic [7:0] e;
      if (!rst) begin
         prev_v = 1'b0;
      end else begin
         if (prev_v && !prev_r) begin
            checks++;
            if (!(tx_valid && tx_data == prev_d)) begin
               errors++;
               $display("FAIL hold: tx_valid=%0b tx_data=%02h, required valid=1 data=%02h", tx_valid, tx_data, prev_d);
            end
         end
         if (tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got %02h with empty scoreboard", tx_data);
            end else begin
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  errors++;
                  $display("FAIL byte%0d: got %02h, expected %02h", acc_cnt, tx_data, e);
               end
            end
            acc_cnt++;
         end
         prev_v = tx_valid;
         prev_r = tx_ready;
         prev_d = tx_data;
      end
   end

   task automatic tick();
      @(posedge clk_ULPI);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Queue one packet into the FIFOs and its hand-computed record into the scoreboard
   task automatic push_rec(input logic [15:0] info, input int n,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] csum_exp, input bit load_data);
      logic [7:0] pl [4];
      pl[0] = b0; pl[1] = b1; pl[2] = b2; pl[3] = b3;
      exp_q.push_back(8'hA5);
      exp_q.push_back(info[15:8]);
      exp_q.push_back(info[7:0]);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pl[i]);
         if (load_data) data_q.push_back(pl[i]);
      end
      exp_q.push_back(csum_exp);
      info_q.push_back(info);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      tick();
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL %s_timeout: %0d bytes still expected, busy=%0b", name, exp_q.size(), busy);
      end
   endtask

   initial begin
      int ib, db, n;
      // Reset
      #1 rst = 1'b0;
      repeat (3) tick();
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data",  32'(tx_data),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_ovf",      32'(ovf),      32'd0);
      check("rst_pkt_cnt",  32'(pkt_cnt),  32'd0);
      check("rst_readallow",32'(ReadAllow),32'd0);
      check("rst_re",       32'({INFO_re, DATA_re}), 32'd0);
      en  = 1'b1;
      rst = 1'b1;
      repeat (2) tick();
      check("readallow_en", 32'(ReadAllow), 32'd1);

      // 1: three-byte payload, sink always ready
      ib = info_re_cnt; db = data_re_cnt;
      push_rec(16'h0403, 3, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'hD7, 1'b1);
      wait_done("t1");
      check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
      check("t1_info_re", 32'(info_re_cnt - ib), 32'd1);
      check("t1_data_re", 32'(data_re_cnt - db), 32'd3);

      // 2: empty payload
      ib = info_re_cnt; db = data_re_cnt;
      push_rec(16'h0800, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 1'b1);
      wait_done("t2");
      check("t2_busy",    32'(busy), 32'd0);
      check("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);
      check("t2_info_re", 32'(info_re_cnt - ib), 32'd1);
      check("t2_data_re", 32'(data_re_cnt - db), 32'd0);

      // 3: same record with a randomly stalling sink
      rdy_rand = 1'b1;
      push_rec(16'h0403, 3, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'hD7, 1'b1);
      wait_done("t3");
      rdy_rand = 1'b0;
      check("t3_pkt_cnt", 32'(pkt_cnt), 32'd3);

      // 4: payload arrives late; framer must wait in the read state
      n = acc_cnt + 3;
      push_rec(16'h0C02, 2, 8'h55, 8'hAA, 8'h00, 8'h00, 8'hF1, 1'b0);
      begin
         int k = 0;
         while (acc_cnt < n && k < 500) begin tick(); k++; end
         check("t4_hdr_sent", 32'(acc_cnt >= n), 32'd1);
      end
      db = data_re_cnt;
      repeat (50) tick();
      check("t4_no_data_re", 32'(data_re_cnt - db), 32'd0);
      check("t4_busy",       32'(busy),     32'd1);
      check("t4_tx_valid",   32'(tx_valid), 32'd0);
      data_q.push_back(8'h55);
      data_q.push_back(8'hAA);
      wait_done("t4");
      check("t4_pkt_cnt", 32'(pkt_cnt), 32'd4);
      check("t4_data_re", 32'(data_re_cnt - db), 32'd2);

      // 5: overflow status and ReadAllow gating
      check("t5_pre_ovf", 32'(ovf), 32'd0);
      DATA_full = 1'b1;
      tick();
      DATA_full = 1'b0;
      check("t5_readallow_low", 32'(ReadAllow), 32'd0);
      check("t5_ovf_set",       32'(ovf),       32'd1);
      repeat (3) tick();
      check("t5_readallow_back", 32'(ReadAllow), 32'd1);
      check("t5_ovf_sticky",     32'(ovf),       32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t5_ovf_clr", 32'(ovf), 32'd0);
      tick();
      DATA_full = 1'b1;
      clr_ovf   = 1'b1;
      tick();
      DATA_full = 1'b0;
      clr_ovf   = 1'b0;
      check("t5_set_wins", 32'(ovf), 32'd1);
      repeat (2) tick();
      en = 1'b0;
      repeat (2) tick();
      check("t5_readallow_en0", 32'(ReadAllow), 32'd0);
      en = 1'b1;
      INFO_full = 1'b1;
      repeat (2) tick();
      check("t5_readallow_infofull", 32'(ReadAllow), 32'd0);
      INFO_full = 1'b0;
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;

      // 6: reset during the second payload byte
      push_rec(16'h1004, 4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h50, 1'b1);
      begin
         int k = 0;
         while (!(tx_valid && tx_data == 8'h22) && k < 500) begin tick(); k++; end
         check("t6_reached_byte2", 32'(k < 500), 32'd1);
      end
      #2 rst = 1'b0;
      #1;
      check("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
      check("t6_rst_tx_data",  32'(tx_data),  32'd0);
      check("t6_rst_busy",     32'(busy),     32'd0);
      check("t6_rst_pkt_cnt",  32'(pkt_cnt),  32'd0);
      check("t6_rst_ovf_ra",   32'({ovf, ReadAllow, INFO_re, DATA_re}), 32'd0);
      exp_q.delete();
      info_q.delete();
      data_q.delete();
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      push_rec(16'h0401, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h5F, 1'b1);
      wait_done("t6");
      check("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);

      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
